led_fade_pwm: RTL and testbench
===============================

Name: led_fade_pwm

Overview:
- Downstream stage of the 4-LED chaser.
- Consumes the chaser's one-hot LED pattern and drives the physical LED pins through per-channel PWM.
- A lit input holds its channel at full brightness. When the input drops, the channel fades out in fixed steps, giving a comet-tail effect behind the moving light.
- Sits between the chaser outputs and the board LED pins, in the same clock domain.

Parameters:
- N_LED, 4, number of LED channels.
- PWM_BITS, 8, brightness/PWM counter width; MAX = 2^PWM_BITS-1.
- DECAY_DIV, 250000, clk cycles per decay tick (2 ms at 125 MHz); must be >= 2.
- DECAY_STEP, 16, brightness decrement per decay tick; must be >= 1 and <= MAX.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = normal operation; 0 = LEDs dark, levels cleared, counters held.
- led_in  input  N_LED  LED pattern from the chaser, same clock domain, 1 = lit.
- pwm_out  output  N_LED  PWM drive to LED pins, registered.
- level_bus  output  N_LED*PWM_BITS  current brightness per channel, channel i at bits [i*PWM_BITS +: PWM_BITS], registered, for debug.

Behaviour:
- Reset (reset=1 at a clk edge), applied the next cycle:
  - led_q, level[i], pwm_cnt, div_cnt, decay_tick all 0.
  - pwm_out = 0 and level_bus = 0.
  - reset overrides enable and led_in.
- Input stage: led_q <= led_in, one register stage.
- PWM counter:
  - pwm_cnt (PWM_BITS wide) increments every cycle while enable=1.
  - Wraps MAX -> 0.
  - Holds its value while enable=0.
- Decay prescaler:
  - div_cnt counts 0..DECAY_DIV-1 while enable=1.
  - decay_tick is a registered one-cycle pulse asserted the cycle after div_cnt == DECAY_DIV-1; div_cnt returns to 0 at that point.
  - Both hold while enable=0, and decay_tick is forced to 0.
- Level update per channel, each cycle, in priority order:
  1. enable=0: level <= 0.
  2. led_q[i]=1: level <= MAX. Set wins over a simultaneous decay_tick.
  3. decay_tick=1: saturating subtract. level <= (level > DECAY_STEP) ? level-DECAY_STEP : 0.
  4. Otherwise: hold.
- PWM output:
  - pwm_out[i] <= enable & ((level[i] == MAX) | (level[i] > pwm_cnt)).
  - Duty is level/2^PWM_BITS, except level=MAX, which is always on (100%). Level 0 is always off.
- Latency:
  - led_in rising -> led_q +1 -> level=MAX +2 -> pwm_out high +3 cycles.
  - Same 3-cycle path for the effect of a fall on the decay start. Decay timing is set by decay_tick, not by the fall.
- level_bus mirrors the level registers directly, with no extra delay.
- Boundary conditions:
  - Level never underflows below 0 and never exceeds MAX.
  - Multiple led_in bits high simultaneously is legal; each channel is independent.
  - Dropping enable mid-fade: pwm_out = 0 and levels = 0 on the next edge. On re-enable, counters resume from their held values and levels rebuild from led_in.
  - Reset mid-fade has the same effect as reset from idle.

Test Plan (use PWM_BITS=4, DECAY_DIV=4, DECAY_STEP=4, so MAX=15):
1. Reset during activity:
   - Stimulus: reset=1 for 3 cycles with enable=1 and led_in=4'b1111.
   - Required: pwm_out=0 and level_bus=0 throughout.
   - After release: level=15 on all channels at cycle +2, pwm_out=4'b1111 at cycle +3.
2. Steady lit channel:
   - Stimulus: led_in=4'b0001 held for 64 cycles.
   - Required: pwm_out[0]=1 every cycle, pwm_out[3:1]=0, level[0]=15.
3. Fade:
   - Stimulus: drop led_in[0] to 0.
   - Required: level[0] steps 15 -> 11 -> 7 -> 3 -> 0, one step per decay_tick (every 4 cycles).
   - Over a 16-cycle pwm_cnt period at level 11, pwm_out[0] is high for exactly 11 cycles; at level 3, exactly 3 cycles; then stays 0.
4. Set/decay collision:
   - Stimulus: raise led_in[1] so led_q[1]=1 lands in the same cycle as decay_tick, with level[1]=7.
   - Required: level[1]=15 next cycle, not 3.
5. Enable drop mid-fade:
   - Stimulus: enable=0 while level[2]=11; hold enable=0 for 10 cycles.
   - Required: pwm_out=0 and level[2]=0 next cycle; pwm_cnt and div_cnt unchanged over the 10 cycles.
   - Stimulus: enable=1 with led_in=4'b0100.
   - Required: level[2]=15 two cycles later.
6. Chaser rotation:
   - Stimulus: led_in rotates 0001 -> 0010 -> 0100 -> 1000 every 8 cycles.
   - Required: the current channel is at 15, the previous channel at 11 or 7, and the channel two positions back at 7 or lower. Exact values are checked against a reference model cycle by cycle.

Source files
------------

// File: rtl/led_fade_pwm.sv
`default_nettype none
// ============================================================================
// Module      : led_fade_pwm
// Description : Per-channel PWM LED driver with a comet-tail fade. A lit input
//               pins its channel at full brightness. Once the input drops, the
//               channel loses DECAY_STEP of brightness on every decay tick
//               until it reaches zero.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1                system clock
//   reset      in   1                synchronous, active-high reset
//   enable     in   1                1 = run; 0 = dark, levels cleared,
//                                    counters held
//   led_in     in   N_LED            chaser pattern, 1 = lit
//   pwm_out    out  N_LED            registered PWM drive to the LED pins
//   level_bus  out  N_LED*PWM_BITS   registered brightness, channel i at
//                                    [i*PWM_BITS +: PWM_BITS]
// ============================================================================
module led_fade_pwm #(
  parameter int N_LED      = 4,
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 250000,
  parameter int DECAY_STEP = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [N_LED-1:0]          led_in,
  output logic [N_LED-1:0]          pwm_out,
  output logic [N_LED*PWM_BITS-1:0] level_bus
);

  localparam int                    c_DIV_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PWM_BITS-1:0]   c_MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0]   c_STEP     = PWM_BITS'(DECAY_STEP);
  localparam logic [c_DIV_W-1:0]    c_DIV_LAST = c_DIV_W'(DECAY_DIV - 1);

  logic [N_LED-1:0]    r_led_q;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [c_DIV_W-1:0]  r_div_cnt;
  logic                r_decay_tick;

  // Single input register stage from the chaser.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led_q <= '0;
    end else begin
      r_led_q <= led_in;
    end
  end

  // Shared PWM ramp and decay prescaler. Both freeze while disabled so that
  // re-enabling resumes from the same phase; the tick itself is squashed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm_cnt    <= '0;
      r_div_cnt    <= '0;
      r_decay_tick <= 1'b0;
    end else if (enable) begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_div_cnt == c_DIV_LAST) begin
        r_div_cnt    <= '0;
        r_decay_tick <= 1'b1;
      end else begin
        r_div_cnt    <= r_div_cnt + 1'b1;
        r_decay_tick <= 1'b0;
      end
    end else begin
      r_decay_tick <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_LED; gi++) begin : g_chan
      logic [PWM_BITS-1:0] r_level;
      logic [PWM_BITS-1:0] w_level_nxt;
      logic                r_pwm;

      // Priority: disable clears, a lit input beats a coincident decay tick,
      // decay saturates at zero.
      always_comb begin
        w_level_nxt = r_level;
        if (!enable) begin
          w_level_nxt = '0;
        end else if (r_led_q[gi]) begin
          w_level_nxt = c_MAX;
        end else if (r_decay_tick) begin
          w_level_nxt = (r_level > c_STEP) ? (r_level - c_STEP) : '0;
        end
      end

      // Full scale is forced on so a lit LED never shows the one-cycle gap
      // a plain level > cnt compare would leave at cnt == MAX.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_level <= '0;
          r_pwm   <= 1'b0;
        end else begin
          r_level <= w_level_nxt;
          r_pwm   <= enable & ((r_level == c_MAX) | (r_level > r_pwm_cnt));
        end
      end

      assign pwm_out[gi]                         = r_pwm;
      assign level_bus[gi*PWM_BITS +: PWM_BITS]  = r_level;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_fade_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_fade_pwm
// Description : Self-checking bench for led_fade_pwm (PWM_BITS=4,
//               DECAY_DIV=4, DECAY_STEP=4, MAX=15).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_fade_pwm;

  localparam int NL   = 4;
  localparam int PB   = 4;
  localparam int DIV  = 4;
  localparam int STEP = 4;
  localparam int MAXV = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  led_in;
  logic [3:0]  pwm_out;
  logic [15:0] level_bus;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_fade_pwm #(
    .N_LED      (NL),
    .PWM_BITS   (PB),
    .DECAY_DIV  (DIV),
    .DECAY_STEP (STEP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .led_in    (led_in),
    .pwm_out   (pwm_out),
    .level_bus (level_bus)
  );

  // Reference model: brightness as plain integers, the two counters derived
  // from the number of enabled cycles since reset.
  int         m_lvl [4];
  logic [3:0] m_ledq;
  logic [3:0] m_pwm;
  int         m_nen;
  bit         m_tick;

  task automatic model_edge(input bit r, input bit e, input logic [3:0] l);
    int pc;
    if (r) begin
      for (int i = 0; i < 4; i++) m_lvl[i] = 0;
      m_ledq = '0; m_pwm = '0; m_nen = 0; m_tick = 1'b0;
    end else begin
      pc = m_nen % (MAXV + 1);
      for (int i = 0; i < 4; i++)
        m_pwm[i] = e && (m_lvl[i] == MAXV || m_lvl[i] > pc);
      for (int i = 0; i < 4; i++) begin
        if (!e)               m_lvl[i] = 0;
        else if (m_ledq[i])   m_lvl[i] = MAXV;
        else if (m_tick)      m_lvl[i] = (m_lvl[i] > STEP) ? m_lvl[i] - STEP : 0;
      end
      if (e) begin
        m_nen  = m_nen + 1;
        m_tick = (m_nen % DIV) == 0;
      end else begin
        m_tick = 1'b0;
      end
      m_ledq = l;
    end
  endtask

  function automatic logic [15:0] m_bus();
    logic [15:0] b;
    for (int i = 0; i < 4; i++) b[i*4 +: 4] = m_lvl[i][3:0];
    return b;
  endfunction

  function automatic int lvl(input int ch);
    return int'(level_bus[ch*4 +: 4]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive, update the model at the edge, compare 1 ns later.
  task automatic cyc(input bit r, input bit e, input logic [3:0] l);
    reset  = r;
    enable = e;
    led_in = l;
    @(posedge clk);
    model_edge(r, e, l);
    #1;
    check("model_pwm",   32'(pwm_out),   32'(m_pwm));
    check("model_level", 32'(level_bus), 32'(m_bus()));
  endtask

  typedef struct {
    bit          rst;
    bit          en;
    logic [3:0]  led;
    int          hold;
    logic [3:0]  epwm;
    logic [15:0] elvl;
  } vec_t;

  vec_t vt [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[$];
    int tchg[$];
    int exp_f[5];
    bit found;
    bit stays_dark;
    logic [3:0] rled;
    int v;

    reset = 1'b1; enable = 1'b1; led_in = 4'b1111;

    // ---------------- table-driven vectors ----------------
    vt[0]  = '{1'b1, 1'b1, 4'b1111,  3, 4'b0000, 16'h0000};
    vt[1]  = '{1'b0, 1'b1, 4'b1111,  1, 4'b0000, 16'h0000};
    vt[2]  = '{1'b0, 1'b1, 4'b1111,  1, 4'b0000, 16'hFFFF};
    vt[3]  = '{1'b0, 1'b1, 4'b1111,  1, 4'b1111, 16'hFFFF};
    vt[4]  = '{1'b1, 1'b1, 4'b0001,  1, 4'b0000, 16'h0000};
    vt[5]  = '{1'b0, 1'b1, 4'b0001,  1, 4'b0000, 16'h0000};
    vt[6]  = '{1'b0, 1'b1, 4'b0001,  1, 4'b0000, 16'h000F};
    vt[7]  = '{1'b0, 1'b1, 4'b0001, 64, 4'b0001, 16'h000F};
    vt[8]  = '{1'b0, 1'b0, 4'b0001,  3, 4'b0000, 16'h0000};
    vt[9]  = '{1'b0, 1'b1, 4'b0001,  1, 4'b0000, 16'h000F};
    vt[10] = '{1'b0, 1'b1, 4'b0001,  1, 4'b0001, 16'h000F};

    for (int k = 0; k < 11; k++) begin
      for (int h = 0; h < vt[k].hold; h++) begin
        cyc(vt[k].rst, vt[k].en, vt[k].led);
        check($sformatf("vec%0d_pwm", k),   32'(pwm_out),   32'(vt[k].epwm));
        check($sformatf("vec%0d_level", k), 32'(level_bus), 32'(vt[k].elvl));
      end
    end

    // ---------------- fade of channel 0 ----------------
    exp_f = '{15, 11, 7, 3, 0};
    stays_dark = 1'b1;
    for (int t = 0; t < 40; t++) begin
      cyc(1'b0, 1'b1, 4'b0000);
      v = lvl(0);
      if (seq.size() == 0 || v != seq[$]) begin
        seq.push_back(v);
        tchg.push_back(t);
      end
      if (t >= 24 && pwm_out[0]) stays_dark = 1'b0;
    end
    check("fade_steps", 32'(seq.size()), 32'd5);
    for (int j = 0; j < 5; j++)
      if (j < seq.size()) check($sformatf("fade_val%0d", j), 32'(seq[j]), 32'(exp_f[j]));
    for (int j = 2; j < 5; j++)
      if (j < tchg.size()) check($sformatf("fade_gap%0d", j), 32'(tchg[j] - tchg[j-1]), 32'(DIV));
    check("fade_dark", 32'(stays_dark), 32'd1);

    // ---------------- set / decay collision on channel 1 ----------------
    repeat (3) cyc(1'b0, 1'b1, 4'b0010);
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      cyc(1'b0, 1'b1, 4'b0000);
      if (lvl(1) == 7) found = 1'b1;
    end
    check("collide_reach7", 32'(found), 32'd1);
    if (found) begin
      cyc(1'b0, 1'b1, 4'b0000);
      cyc(1'b0, 1'b1, 4'b0000);
      cyc(1'b0, 1'b1, 4'b0010);
      check("collide_pre", 32'(lvl(1)), 32'd7);
      cyc(1'b0, 1'b1, 4'b0010);
      check("collide_set", 32'(lvl(1)), 32'd15);
    end

    // ---------------- enable drop mid-fade on channel 2 ----------------
    repeat (3) cyc(1'b0, 1'b1, 4'b0100);
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      cyc(1'b0, 1'b1, 4'b0000);
      if (lvl(2) == 11) found = 1'b1;
    end
    check("endrop_reach11", 32'(found), 32'd1);
    for (int t = 0; t < 10; t++) begin
      cyc(1'b0, 1'b0, 4'b0000);
      check($sformatf("endrop_dark%0d", t), 32'({pwm_out, level_bus}), 32'd0);
    end
    cyc(1'b0, 1'b1, 4'b0100);
    check("reen_c1", 32'(lvl(2)), 32'd0);
    cyc(1'b0, 1'b1, 4'b0100);
    check("reen_c2", 32'(lvl(2)), 32'd15);

    // ---------------- chaser rotation ----------------
    cyc(1'b1, 1'b1, 4'b0000);
    for (int seg = 0; seg < 12; seg++) begin
      repeat (8) cyc(1'b0, 1'b1, 4'(1 << (seg % 4)));
      if (seg >= 1) begin
        check($sformatf("rot%0d_cur", seg), 32'(lvl(seg % 4)), 32'd15);
        v = lvl((seg + 3) % 4);
        check($sformatf("rot%0d_prev_%0d", seg, v), 32'(v == 11 || v == 7), 32'd1);
        v = lvl((seg + 2) % 4);
        check($sformatf("rot%0d_back2_%0d", seg, v), 32'(v <= 7), 32'd1);
      end
    end

    // ---------------- randomized run against the model ----------------
    rled = 4'b0001;
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 7) == 0) rled = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), rled);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
